app_req_master: RTL

APP_REQ_MASTER -- requirements
Module: app_req_master

---
 rtl/app_req_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/app_req_master.sv
// app_req_master: issues one SDRAM controller burst per command.
// Writes drive seed+beat data; reads check returned data against the same pattern.
// Ports:
//   sdram_clk, reset          : clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*    : command handshake, direction, address, length, seed
//   app_req*, app_req_ack     : controller request and acknowledge
//   app_wr_*, app_rd_*        : write data and enables, read data and valid
//   app_last_rd, app_last_wr  : controller end-of-burst markers
//   done, tmo                 : one-cycle completion pulse, timeout flag
//   err_cnt, err_clr          : saturating read-mismatch count and its clear
module app_req_master #(
  parameter int APP_AW = 26,
  parameter int APP_RW = 9,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int TMO_W  = 12
) (
  input  logic              sdram_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr_n,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [APP_RW-1:0] cmd_len,
  input  logic [APP_DW-1:0] cmd_seed,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [APP_RW-1:0] app_req_len,
  output logic              app_req_wr_n,
  output logic              app_req_wrap,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_req_ack,
  input  logic              app_wr_next_req,
  input  logic              app_rd_valid,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_last_rd,
  input  logic              app_last_wr,
  output logic              done,
  output logic              tmo,
  output logic [15:0]       err_cnt,
  input  logic              err_clr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

  // Expiry fires on the (2^TMO_W-1)th consecutive idle cycle.
  localparam logic [TMO_W-1:0] WD_LAST =
    {{(TMO_W-1){1'b1}}, 1'b0};

  state_t              r_state;
  logic                r_wr_n;
  logic [APP_AW-1:0]   r_addr;
  logic [APP_RW-1:0]   r_len;
  logic [APP_RW-1:0]   r_beat;
  logic [APP_DW-1:0]   r_pat;
  logic [TMO_W-1:0]    r_wd;
  logic                r_app_req;
  logic                r_done;
  logic                r_tmo;
  logic [15:0]         r_err;

  logic                w_busy;
  logic                w_wr_beat;
  logic                w_rd_beat;
  logic                w_kick;
  logic                w_wd_exp;
  logic                w_mis;
  logic [APP_RW:0]     w_beat_nxt;
  logic                w_beat_end;

  assign w_busy = (r_state == ST_REQ) ||
                  (r_state == ST_WDATA) ||
                  (r_state == ST_RDATA);

  assign w_wr_beat = app_wr_next_req && !r_wr_n &&
                     ((r_state == ST_REQ) ||
                      (r_state == ST_WDATA));

  assign w_rd_beat = app_rd_valid &&
                     (r_state == ST_RDATA);

  assign w_kick = ((r_state == ST_REQ) && app_req_ack) ||
                  w_wr_beat || w_rd_beat;

  assign w_wd_exp = w_busy && !w_kick &&
                    (r_wd == WD_LAST);

  // r_pat always equals seed + beat_idx.
  assign w_mis = w_rd_beat && (app_rd_data != r_pat);

  assign w_beat_nxt = {1'b0, r_beat} + 1'b1;
  assign w_beat_end = (w_beat_nxt == {1'b0, r_len});

  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wr_n    <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_pat     <= '0;
      r_wd      <= '0;
      r_app_req <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_err     <= '0;
    end else begin
      r_done <= 1'b0;

      if (err_clr)
        r_err <= '0;
      else if (w_mis && (r_err != 16'hFFFF))
        r_err <= r_err + 1'b1;

      if (w_busy)
        r_wd <= w_kick ? '0 : r_wd + 1'b1;

      if (w_wr_beat || w_rd_beat) begin
        r_beat <= r_beat + 1'b1;
        r_pat  <= r_pat + 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_wr_n    <= cmd_wr_n;
            r_addr    <= cmd_addr;
            r_len     <= cmd_len;
            r_beat    <= '0;
            r_pat     <= cmd_seed;
            r_wd      <= '0;
            r_tmo     <= 1'b0;
            r_app_req <= (cmd_len != '0);
            r_state   <= (cmd_len == '0) ?
                         ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_wd_exp) begin
            r_app_req <= 1'b0;
            r_tmo     <= 1'b1;
            r_state   <= ST_DONE;
          end else if (app_req_ack) begin
            r_app_req <= 1'b0;
            r_state   <= r_wr_n ? ST_RDATA : ST_WDATA;
          end
        end
        ST_WDATA: begin
          // Beats may already be complete if the
          // controller pulled them before acking.
          if (w_wd_exp) begin
            r_tmo   <= 1'b1;
            r_state <= ST_DONE;
          end else if ((w_wr_beat && w_beat_end) ||
                       app_last_wr ||
                       (r_beat == r_len)) begin
            r_state <= ST_DONE;
          end
        end
        ST_RDATA: begin
          if (w_wd_exp) begin
            r_tmo   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_rd_beat &&
                       (w_beat_end || app_last_rd)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == ST_IDLE);
  assign app_req      = r_app_req;
  assign app_req_addr = r_addr;
  assign app_req_len  = r_len;
  assign app_req_wr_n = r_wr_n;
  assign app_req_wrap = 1'b0;
  assign app_wr_data  = r_pat;
  assign app_wr_en_n  = '0;
  assign done         = r_done;
  assign tmo          = r_tmo;
  assign err_cnt      = r_err;

endmodule
